// File: rtl/trng_health_monitor.sv
// trng_health_monitor: online health tests for a TRNG byte stream.
// A repetition count test and an adaptive proportion test check every
// accepted sample. Samples go downstream only once the start-up period
// has passed cleanly. Any test failure latches a sticky fault, and the
// block then stays silent until reset.
//
// Input handshake: there is no backpressure. sample_i is consumed on
// every rising edge where sample_valid_i is high, except in FAIL, where
// it is ignored. data_valid_o is a one-cycle strobe that qualifies
// data_out_o. data_out_o holds its last value while the strobe is low.
module trng_health_monitor #(
  parameter int unsigned RCT_CUTOFF      = 5,
  parameter int unsigned APT_WINDOW      = 512,
  parameter int unsigned APT_CUTOFF      = 13,
  parameter int unsigned STARTUP_SAMPLES = 1024
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic [7:0] sample_i,
  input  logic       sample_valid_i,
  output logic [7:0] data_out_o,
  output logic       data_valid_o,
  output logic       healthy_o,
  output logic       rct_fail_o,
  output logic       apt_fail_o,
  output logic [1:0] state_o
);

  localparam int unsigned AW = $clog2(APT_WINDOW) + 1;
  localparam logic [7:0]    RCT_CUT = 8'(RCT_CUTOFF);
  localparam logic [AW-1:0] APT_CUT = AW'(APT_CUTOFF);
  localparam logic [AW-1:0] APT_WIN = AW'(APT_WINDOW);
  localparam logic [AW-1:0] AW_MAX  = {AW{1'b1}};
  localparam logic [15:0]   SU_CNT  = 16'(STARTUP_SAMPLES);

  typedef enum logic [1:0] {
    ST_STARTUP = 2'd0,
    ST_RUN     = 2'd1,
    ST_FAIL    = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    last_q, last_d;
  logic [7:0]    rct_cnt_q, rct_cnt_d;
  logic [7:0]    ref_q, ref_d;
  logic [AW-1:0] apt_cnt_q, apt_cnt_d;
  logic [AW-1:0] win_idx_q, win_idx_d;
  logic [15:0]   su_cnt_q, su_cnt_d;
  logic [7:0]    data_out_q, data_out_d;
  logic          data_valid_q, data_valid_d;
  logic          healthy_q, healthy_d;
  logic          rct_fail_q, rct_fail_d;
  logic          apt_fail_q, apt_fail_d;

  logic          accept;
  logic          rct_trip, apt_trip;
  logic [7:0]    rct_new;
  logic [AW-1:0] apt_new, win_new;

  // Register all state, counters and outputs; reset discards partial counts.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= ST_STARTUP;
      last_q       <= 8'd0;
      rct_cnt_q    <= 8'd0;
      ref_q        <= 8'd0;
      apt_cnt_q    <= '0;
      win_idx_q    <= '0;
      su_cnt_q     <= 16'd0;
      data_out_q   <= 8'd0;
      data_valid_q <= 1'b0;
      healthy_q    <= 1'b0;
      rct_fail_q   <= 1'b0;
      apt_fail_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      rct_cnt_q    <= rct_cnt_d;
      ref_q        <= ref_d;
      apt_cnt_q    <= apt_cnt_d;
      win_idx_q    <= win_idx_d;
      su_cnt_q     <= su_cnt_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
      healthy_q    <= healthy_d;
      rct_fail_q   <= rct_fail_d;
      apt_fail_q   <= apt_fail_d;
    end
  end

  // Evaluate both tests on each accepted sample, then decide the next state and forwarding.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    rct_cnt_d    = rct_cnt_q;
    ref_d        = ref_q;
    apt_cnt_d    = apt_cnt_q;
    win_idx_d    = win_idx_q;
    su_cnt_d     = su_cnt_q;
    data_out_d   = data_out_q;
    data_valid_d = 1'b0;
    rct_fail_d   = rct_fail_q;
    apt_fail_d   = apt_fail_q;
    rct_trip     = 1'b0;
    apt_trip     = 1'b0;
    rct_new      = rct_cnt_q;
    apt_new      = apt_cnt_q;
    win_new      = win_idx_q;

    // A zero run count means no sample has been seen since reset.
    accept = sample_valid_i && (state_q != ST_FAIL);

    if (accept) begin
      // Repetition count: a new value starts a new run of length one.
      if ((rct_cnt_q == 8'd0) || (sample_i != last_q)) begin
        rct_new = 8'd1;
      end else begin
        rct_new = (rct_cnt_q == 8'hFF) ? rct_cnt_q : rct_cnt_q + 8'd1;
      end
      last_d    = sample_i;
      rct_cnt_d = rct_new;
      rct_trip  = (rct_new == RCT_CUT);

      // Adaptive proportion: the first sample of each window is the reference.
      if (win_idx_q == '0) begin
        ref_d   = sample_i;
        apt_new = AW'(1);
        win_new = AW'(1);
      end else begin
        if (sample_i == ref_q) begin
          apt_new = (apt_cnt_q == AW_MAX) ? apt_cnt_q : apt_cnt_q + AW'(1);
        end
        win_new = (win_idx_q == AW_MAX) ? win_idx_q : win_idx_q + AW'(1);
        if (win_new == APT_WIN) begin
          win_new = '0;
        end
      end
      apt_cnt_d = apt_new;
      win_idx_d = win_new;
      apt_trip  = (apt_new == APT_CUT);

      su_cnt_d = (su_cnt_q == 16'hFFFF) ? su_cnt_q : su_cnt_q + 16'd1;

      if (rct_trip || apt_trip) begin
        state_d    = ST_FAIL;
        rct_fail_d = rct_fail_q | rct_trip;
        apt_fail_d = apt_fail_q | apt_trip;
      end else if (state_q == ST_RUN) begin
        data_valid_d = 1'b1;
        data_out_d   = sample_i;
      end else if (su_cnt_d == SU_CNT) begin
        // The sample that completes start-up is tested but not forwarded.
        state_d = ST_RUN;
      end
    end

    healthy_d = (state_d == ST_RUN);
  end

  assign data_out_o   = data_out_q;
  assign data_valid_o = data_valid_q;
  assign healthy_o    = healthy_q;
  assign rct_fail_o   = rct_fail_q;
  assign apt_fail_o   = apt_fail_q;
  assign state_o      = state_q;

endmodule

// File: tb/tb_trng_health_monitor.sv
// tb_trng_health_monitor: directed scenarios plus randomized streams.
// Every cycle is compared against a behavioural model of the health tests.
module tb_trng_health_monitor;

  // Clock and reset.
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic [7:0] sample = 8'd0;
  logic       sample_valid = 1'b0;
  logic [7:0] data_out;
  logic       data_valid, healthy, rct_fail, apt_fail;
  logic [1:0] state_dbg;

  trng_health_monitor dut (
    .clk_i          (clk),
    .reset_i        (reset),
    .sample_i       (sample),
    .sample_valid_i (sample_valid),
    .data_out_o     (data_out),
    .data_valid_o   (data_valid),
    .healthy_o      (healthy),
    .rct_fail_o     (rct_fail),
    .apt_fail_o     (apt_fail),
    .state_o        (state_dbg)
  );

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // Behavioural model, in terms of runs, window positions and reference tallies.
  localparam int RCT_CUT = 5;
  localparam int APT_WIN = 512;
  localparam int APT_CUT = 13;
  localparam int SU_N    = 1024;

  int         m_phase;   // 0 start-up, 1 running, 2 failed
  int         m_n;       // accepted samples since reset
  logic [7:0] m_prev;
  int         m_run;
  logic [7:0] m_ref;
  int         m_refcnt;
  logic [7:0] e_data;
  logic       e_valid, e_healthy, e_rct, e_apt;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_data_out"}, data_out, e_data);
    chk({tag, "_data_valid"}, {7'd0, data_valid}, {7'd0, e_valid});
    chk({tag, "_healthy"}, {7'd0, healthy}, {7'd0, e_healthy});
    chk({tag, "_rct_fail"}, {7'd0, rct_fail}, {7'd0, e_rct});
    chk({tag, "_apt_fail"}, {7'd0, apt_fail}, {7'd0, e_apt});
  endtask

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_prev = 8'd0; m_run = 0; m_ref = 8'd0; m_refcnt = 0;
    e_data = 8'd0; e_valid = 1'b0; e_healthy = 1'b0; e_rct = 1'b0; e_apt = 1'b0;
  endtask

  task automatic model_update(input logic v, input logic [7:0] s);
    bit rt, at;
    e_valid = 1'b0;
    if (!v || m_phase == 2) return;
    m_run = (m_n > 0 && s == m_prev) ? m_run + 1 : 1;
    m_prev = s;
    if (m_n % APT_WIN == 0) begin
      m_ref = s;
      m_refcnt = 1;
    end else if (s == m_ref) begin
      m_refcnt++;
    end
    m_n++;
    rt = (m_run == RCT_CUT);
    at = (m_refcnt == APT_CUT);
    if (rt || at) begin
      m_phase = 2;
      e_rct = e_rct | rt;
      e_apt = e_apt | at;
    end else if (m_phase == 1) begin
      e_valid = 1'b1;
      e_data = s;
    end else if (m_n == SU_N) begin
      m_phase = 1;
    end
    e_healthy = (m_phase == 1);
  endtask

  // Driver tasks: inputs change on the falling edge, outputs are sampled 1 time unit after the rising edge.
  task automatic step(input logic v, input logic [7:0] s, input string tag);
    @(negedge clk);
    reset = 1'b0;
    sample_valid = v;
    sample = s;
    @(posedge clk);
    #1;
    model_update(v, s);
    check_all(tag);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    sample_valid = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_all("reset");
  endtask

  task automatic startup_clean();
    for (int i = 0; i < SU_N; i++) step(1'b1, 8'(i), "su");
  endtask

  // Window sample p: exactly 12 copies of the reference r, with no other value repeated enough to trip.
  function automatic logic [7:0] wrap_val(input int p, input logic [7:0] r);
    logic [7:0] v;
    if (p % 40 == 0 && p < 480) return r;
    v = 8'(p);
    if (v == r) v = v ^ 8'h01;
    return v;
  endfunction

  // Directed and randomized scenarios.
  initial begin
    bit seen;
    logic [7:0] o;
    model_reset();

    // Incrementing stream, no failure.
    do_reset();
    seen = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      step(1'b1, 8'(i), "inc");
      if (data_valid && !seen) begin
        seen = 1'b1;
        chk("inc_first_data", data_out, 8'h00);
        chk("inc_first_idx", 8'(i >> 2), 8'(1024 >> 2));
      end
      if (i == 1022) chk("inc_not_yet_healthy", {7'd0, healthy}, 8'd0);
      if (i == 1023) chk("inc_healthy_rise", {7'd0, healthy}, 8'd1);
    end
    chk("inc_no_rct", {7'd0, rct_fail}, 8'd0);
    chk("inc_no_apt", {7'd0, apt_fail}, 8'd0);

    // RCT trip in start-up, then further input must stay blocked.
    do_reset();
    for (int i = 0; i < 5; i++) step(1'b1, 8'h3C, "rct");
    chk("rct_flag", {7'd0, rct_fail}, 8'd1);
    chk("rct_apt_clear", {7'd0, apt_fail}, 8'd0);
    for (int i = 0; i < 40; i++) step(1'($urandom_range(0, 1)), 8'($urandom), "rct_after");
    chk("rct_never_healthy", {7'd0, healthy}, 8'd0);

    // APT trip in RUN: reference 0xA5 interleaved with distinct other values.
    do_reset();
    startup_clean();
    step(1'b1, 8'hA5, "apt");
    for (int k = 0; k < 12; k++) begin
      step(1'b1, 8'(k + 1), "apt");
      step(1'b1, 8'hA5, "apt");
      if (k == 10) chk("apt_12th_forwarded", {7'd0, data_valid}, 8'd1);
    end
    chk("apt_flag", {7'd0, apt_fail}, 8'd1);
    chk("apt_healthy_fall", {7'd0, healthy}, 8'd0);
    chk("apt_13th_blocked", {7'd0, data_valid}, 8'd0);

    // APT window wrap: four windows, each with 12 copies of its own reference.
    do_reset();
    startup_clean();
    for (int w = 0; w < 4; w++)
      for (int p = 0; p < APT_WIN; p++) step(1'b1, wrap_val(p, 8'(8'h10 + w * 8'h11)), "wrap");
    chk("wrap_healthy", {7'd0, healthy}, 8'd1);
    chk("wrap_no_apt", {7'd0, apt_fail}, 8'd0);

    // Simultaneous failure: the 5th repeat is also the 13th reference occurrence.
    do_reset();
    startup_clean();
    step(1'b1, 8'h77, "both");
    for (int k = 0; k < 7; k++) begin
      step(1'b1, 8'(k + 1), "both");
      step(1'b1, 8'h77, "both");
    end
    step(1'b1, 8'h42, "both");
    for (int k = 0; k < 5; k++) step(1'b1, 8'h77, "both");
    chk("both_rct", {7'd0, rct_fail}, 8'd1);
    chk("both_apt", {7'd0, apt_fail}, 8'd1);

    // Reset from FAIL, then start-up with sample_valid every other cycle.
    do_reset();
    for (int i = 0; i < SU_N; i++) begin
      step(1'b1, 8'(i), "gap");
      if (i == SU_N - 1) chk("gap_healthy_rise", {7'd0, healthy}, 8'd1);
      step(1'b0, 8'($urandom), "gap");
      if (i == SU_N - 2) chk("gap_not_yet_healthy", {7'd0, healthy}, 8'd0);
    end

    // Randomized streams over full, narrow and medium alphabets with random gaps.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int i = 0; i < 1500; i++) begin
        o = (r == 0) ? 8'($urandom) : (r == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom_range(0, 15));
        step(1'($urandom_range(0, 3) != 0), o, "rand");
      end
    end

    // Final report.
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
